disp_pattern_gen: RTL



---
 rtl/disp_pattern_gen_if.sv | 23 ++
 rtl/disp_pattern_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/disp_pattern_gen_if.sv
// Pixel timing/data bundle between the sync generator, the pattern generator and the frame dump.
interface disp_pattern_gen_if;
    logic [1:0]  i_mode;
    logic        i_vsync;
    logic        i_hsync;
    logic        i_de;
    logic        o_vsync;
    logic        o_hsync;
    logic        o_de;
    logic [23:0] o_data;
    logic [15:0] o_frame_cnt;
    logic        o_geom_err;

    modport master (
        output i_mode, i_vsync, i_hsync, i_de,
        input  o_vsync, o_hsync, o_de, o_data, o_frame_cnt, o_geom_err
    );

    modport slave (
        input  i_mode, i_vsync, i_hsync, i_de,
        output o_vsync, o_hsync, o_de, o_data, o_frame_cnt, o_geom_err
    );
endinterface

// File: rtl/disp_pattern_gen.sv
// Test-pattern pixel source: tracks (x,y) from vsync/hsync/de, emits RGB patterns, checks geometry.
// Optional red frame border enabled by defining DISP_PATTERN_BORDER_EN.
module disp_pattern_gen #(
    parameter int unsigned HRES          = 320,
    parameter int unsigned VRES          = 240,
    parameter int unsigned CHK_SIZE_LOG2 = 4
) (
    input  logic               i_clk,
    input  logic               rst,
    disp_pattern_gen_if.slave  bus
);
    localparam int unsigned XW    = $clog2(HRES) + 1;
    localparam int unsigned YW    = $clog2(VRES) + 1;
    localparam int unsigned BAR_W = HRES / 8;

    localparam logic [XW-1:0] X_LAST = XW'(HRES - 1);
    localparam logic [XW-1:0] X_END  = XW'(HRES);
    localparam logic [YW-1:0] Y_LAST = YW'(VRES - 1);
    localparam logic [YW-1:0] Y_END  = YW'(VRES);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BLANK      = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    fcnt_q, fcnt_d;
    logic           err_q, err_d;
    logic           vs_q, hs_q;
    logic           de_q, de_d;
    logic [23:0]    data_q, data_d;
    logic [XW-1:0]  px;
    logic [YW-1:0]  py;
    logic           frame_start_c;

    // Pattern colour for a saturated in-range coordinate.
    function automatic logic [23:0] pattern(input logic [1:0]    mode,
                                            input logic [XW-1:0] x,
                                            input logic [YW-1:0] y,
                                            input logic [7:0]    fc);
        logic [2:0]  bar;
        logic [23:0] pix;
        bar = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (x < XW'((i + 1) * BAR_W)) bar = 3'(i);
        end
        case (mode)
            2'd0: begin
                case (bar)
                    3'd0:    pix = 24'hFFFFFF;
                    3'd1:    pix = 24'hFFFF00;
                    3'd2:    pix = 24'h00FFFF;
                    3'd3:    pix = 24'h00FF00;
                    3'd4:    pix = 24'hFF00FF;
                    3'd5:    pix = 24'hFF0000;
                    3'd6:    pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            2'd1:    pix = {3{8'(x)}};
            2'd2:    pix = (1'(x >> CHK_SIZE_LOG2) ^ 1'(y >> CHK_SIZE_LOG2)) ? 24'hFFFFFF : 24'h000000;
            default: pix = {8'(x) + fc, 8'(y) + fc, fc};
        endcase
`ifdef DISP_PATTERN_BORDER_EN
        if (x == '0 || x == X_LAST || y == '0 || y == Y_LAST) pix = 24'hFF0000;
`endif
        return pix;
    endfunction

    // vs_q doubles as the previous-vsync sample for edge detection.
    assign frame_start_c = bus.i_vsync & ~vs_q;

    // Next-state, position tracking, geometry checks and pixel generation.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;
        de_d    = 1'b0;
        data_d  = '0;
        px      = '0;
        py      = '0;

        if (frame_start_c) begin
            if (state_q != WAIT_FRAME) begin
                fcnt_d = fcnt_q + 16'd1;
                if (state_q == ACTIVE || y_q != Y_END) err_d = 1'b1;
            end
            mode_d  = bus.i_mode;
            x_d     = '0;
            y_d     = '0;
            state_d = BLANK;
        end else if (state_q == ACTIVE && !bus.i_de) begin
            if (x_q != X_END) err_d = 1'b1;
            if (y_q != Y_END) y_d = y_q + YW'(1);
            x_d     = '0;
            state_d = BLANK;
        end

        // A pixel in a tracked frame uses the frame-start updated mode/count/line.
        if (bus.i_de && state_d != WAIT_FRAME) begin
            px = (x_d > X_LAST) ? X_LAST : x_d;
            py = (y_d > Y_LAST) ? Y_LAST : y_d;
            if (x_d > X_LAST || y_d > Y_LAST) err_d = 1'b1;
            if (x_d != X_END) x_d = x_d + XW'(1);
            state_d = ACTIVE;
            de_d    = 1'b1;
            data_d  = pattern(mode_d, px, py, fcnt_d[7:0]);
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            vs_q    <= bus.i_vsync;
            hs_q    <= bus.i_hsync;
            de_q    <= de_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_vsync     = vs_q;
    assign bus.o_hsync     = hs_q;
    assign bus.o_de        = de_q;
    assign bus.o_data      = data_q;
    assign bus.o_frame_cnt = fcnt_q;
    assign bus.o_geom_err  = err_q;
endmodule
